// File: rtl/peripheral_bcd2bin.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_bcd2bin
// Description : Memory-mapped BCD-to-binary converter for the calculator SoC.
//               Software writes four packed BCD digits to DATA_IN. The block
//               converts them with a reverse double-dabble, one shift per
//               clock over 14 iterations, into a 14-bit binary value. The CPU
//               polls STATUS and then reads RESULT.
//
// Ports       : clk    - system clock
//               reset  - asynchronous, active-high reset
//               d_in   - write data {thousands, hundreds, tens, units}
//               cs     - peripheral select; rd/wr are ignored while low
//               addr   - register offset (00 DATA_IN, 04 STATUS, 08 RESULT)
//               rd     - read strobe
//               wr     - write strobe
//               d_out  - registered read data
//
// Register map: 5'h00 DATA_IN (W) : [15:0] packed BCD operand
//               5'h04 STATUS  (R) : {29'd0, error, done, busy}
//               5'h08 RESULT  (R) : {18'd0, result}; the read clears done
//               other offsets     : read as zero, writes ignored
//
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_bcd2bin (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          C_DIGITS      = 4;
    localparam int          C_BIN_W       = 14;
    localparam int          C_SR_W        = 4 * C_DIGITS + C_BIN_W;
    localparam logic [4:0]  C_ADDR_DATA   = 5'h00;
    localparam logic [4:0]  C_ADDR_STATUS = 5'h04;
    localparam logic [4:0]  C_ADDR_RESULT = 5'h08;
    // cnt counts completed iterations; 13 marks the 14th and final shift.
    localparam logic [3:0]  C_LAST_ITER   = 4'd13;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [C_SR_W-1:0]     r_sr;       // {bcd[15:0], bin[13:0]}
    logic [3:0]            r_cnt;
    logic [C_BIN_W-1:0]    r_result;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [31:0]           r_d_out;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [C_SR_W-1:0]     w_shifted;
    logic [C_SR_W-1:0]     w_next_sr;
    logic [C_DIGITS-1:0]   w_nib_ok;
    logic                  w_all_ok;
    logic                  w_wr_accept;
    logic                  w_rd_access;
    logic                  w_rd_result;
    logic                  w_last_iter;
    logic [31:0]           w_rd_data;

    assign w_shifted = r_sr >> 1;

    // The binary field is simply the shifted-in bits.
    assign w_next_sr[C_BIN_W-1:0] = w_shifted[C_BIN_W-1:0];

    // After the right shift, a BCD digit of 8 or more means a ten from the
    // digit above landed in its MSB as an 8; subtracting 3 corrects 8 to 5,
    // i.e. half of ten, which is what the shift should have produced.
    genvar gi;
    generate
        for (gi = 0; gi < C_DIGITS; gi = gi + 1) begin : g_digit_adjust
            logic [3:0] w_dig;
            assign w_dig = w_shifted[C_BIN_W + 4*gi +: 4];
            assign w_next_sr[C_BIN_W + 4*gi +: 4] = w_dig[3] ? (w_dig - 4'd3) : w_dig;
        end
    endgenerate

    // Operand validity: every nibble must be a decimal digit.
    generate
        for (gi = 0; gi < C_DIGITS; gi = gi + 1) begin : g_digit_check
            assign w_nib_ok[gi] = (d_in[4*gi +: 4] <= 4'd9);
        end
    endgenerate

    assign w_all_ok    = &w_nib_ok;
    // busy is only ever set in ST_SHIFT, so a write while busy is dropped here.
    assign w_wr_accept = cs & wr & (addr == C_ADDR_DATA) & ~r_busy;
    assign w_rd_access = cs & rd;
    assign w_rd_result = w_rd_access & (addr == C_ADDR_RESULT);
    assign w_last_iter = (r_state == ST_SHIFT) && (r_cnt == C_LAST_ITER);

    // Read mux samples the registers before the edge, so a RESULT read on the
    // completing edge returns the previous result.
    always_comb begin
        w_rd_data = 32'd0;
        case (addr)
            C_ADDR_STATUS: w_rd_data = {29'd0, r_error, r_done, r_busy};
            C_ADDR_RESULT: w_rd_data = {{(32-C_BIN_W){1'b0}}, r_result};
            default:       w_rd_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM, datapath and bus read register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_sr     <= '0;
            r_cnt    <= 4'd0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_d_out  <= 32'd0;
        end else begin
            if (w_rd_access) begin
                r_d_out <= w_rd_data;
            end

            // Clear first; any set of done below in this block takes priority.
            if (w_rd_result) begin
                r_done <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_wr_accept) begin
                        if (w_all_ok) begin
                            r_sr    <= {d_in, {C_BIN_W{1'b0}}};
                            r_cnt   <= 4'd0;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_error <= 1'b0;
                            r_state <= ST_SHIFT;
                        end else begin
                            r_error  <= 1'b1;
                            r_done   <= 1'b1;
                            r_result <= '0;
                        end
                    end
                end

                ST_SHIFT: begin
                    r_sr  <= w_next_sr;
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last_iter) begin
                        // BCD field is all zero by now; the binary field holds
                        // the full value (max 9999 fits in 14 bits).
                        r_result <= w_next_sr[C_BIN_W-1:0];
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign d_out = r_d_out;

endmodule
`default_nettype wire
